// File: rtl/bus_gen_arbiter.sv
// bus_gen_arbiter: shared-bus model with one round-robin arbiter per bus.
// Each transaction takes three cycles. IDLE grants a pending terminal. POP strobes
// that terminal's output FIFO and captures its head packet. PUSH strobes the input
// FIFOs of the destination terminals.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous, active-high reset
//   pndng   - [bits][drvrs] terminal output FIFO non-empty
//   push    - [bits][drvrs] one-cycle write strobe into terminal input FIFOs
//   pop     - [bits][drvrs] one-cycle read strobe of terminal output FIFOs
//   D_pop   - [bits][drvrs][pckg_sz] head-of-FIFO data per terminal
//   D_push  - [bits][drvrs][pckg_sz] data presented to terminals, qualified by push
//
// Packet: destination ID in the top 8 bits, payload below; never modified.
//
// Build option: define BCAST_LOOPBACK_EN so that broadcast packets also reach the
// source terminal. By default, broadcast excludes the source.

module bus_gen_arbiter #(
    parameter int unsigned bits      = 1,
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [bits-1:0][drvrs-1:0]             pndng,
    output logic [bits-1:0][drvrs-1:0]             push,
    output logic [bits-1:0][drvrs-1:0]             pop,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    localparam int unsigned PW = (drvrs > 1) ? $clog2(drvrs) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPop  = 2'd1;
    localparam logic [1:0] StPush = 2'd2;

    logic [1:0]         state_q [bits];
    logic [PW-1:0]      ptr_q   [bits];
    logic [PW-1:0]      grant_q [bits];
    logic [PW-1:0]      grant_d [bits];
    logic [pckg_sz-1:0] pkt_q   [bits];
    logic [7:0]         dest    [bits];

    logic [bits-1:0][drvrs-1:0] pop_q;
    logic [bits-1:0][drvrs-1:0] push_q;
    logic [bits-1:0][drvrs-1:0] target;

    int unsigned sum;

    always_comb begin
        sum = 0;
        for (int unsigned b = 0; b < bits; b++) begin
            // Scan from the farthest candidate down to the pointer. The last hit
            // is therefore the first pending terminal at or above the pointer.
            grant_d[b] = ptr_q[b];
            for (int i = int'(drvrs) - 1; i >= 0; i--) begin
                sum = 32'(ptr_q[b]) + 32'(i);
                if (sum >= drvrs) begin
                    sum = sum - drvrs;
                end
                if (pndng[b][sum]) begin
                    grant_d[b] = PW'(sum);
                end
            end

            // An out-of-range unicast ID matches no terminal, so the packet is dropped.
            dest[b] = D_pop[b][grant_q[b]][pckg_sz-1 -: 8];
            for (int unsigned k = 0; k < drvrs; k++) begin
                if (dest[b] == broadcast) begin
`ifdef BCAST_LOOPBACK_EN
                    target[b][k] = 1'b1;
`else
                    target[b][k] = (k != 32'(grant_q[b]));
`endif
                end else begin
                    target[b][k] = (32'(dest[b]) == k);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < bits; b++) begin
            for (int unsigned k = 0; k < drvrs; k++) begin
                D_push[b][k] = pkt_q[b];
            end
        end
    end

    assign pop  = pop_q;
    assign push = push_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_q  <= '0;
            push_q <= '0;
            for (int unsigned b = 0; b < bits; b++) begin
                state_q[b] <= StIdle;
                ptr_q[b]   <= '0;
                grant_q[b] <= '0;
                pkt_q[b]   <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < bits; b++) begin
                case (state_q[b])
                    StIdle: begin
                        if (|pndng[b]) begin
                            grant_q[b]             <= grant_d[b];
                            pop_q[b]               <= '0;
                            pop_q[b][grant_d[b]]   <= 1'b1;
                            state_q[b]             <= StPop;
                        end
                    end
                    StPop: begin
                        pop_q[b]   <= '0;
                        pkt_q[b]   <= D_pop[b][grant_q[b]];
                        push_q[b]  <= target[b];
                        state_q[b] <= StPush;
                        if (32'(grant_q[b]) == drvrs - 1) begin
                            ptr_q[b] <= '0;
                        end else begin
                            ptr_q[b] <= grant_q[b] + 1'b1;
                        end
                    end
                    StPush: begin
                        push_q[b]  <= '0;
                        state_q[b] <= StIdle;
                    end
                    default: begin
                        pop_q[b]   <= '0;
                        push_q[b]  <= '0;
                        state_q[b] <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Testbench for bus_gen_arbiter with bits=1, drvrs=4, pckg_sz=16.
// A table of single-packet transactions is applied and checked.
// Hand-written sequences cover the reset, round-robin and mid-transaction reset cases.

module tb_bus_gen_arbiter;

    logic                    clk;
    logic                    reset;
    logic [0:0][3:0]         pndng;
    logic [0:0][3:0]         push;
    logic [0:0][3:0]         pop;
    logic [0:0][3:0][15:0]   D_pop;
    logic [0:0][3:0][15:0]   D_push;

    int checks;
    int passed;

    bus_gen_arbiter #(
        .bits     (1),
        .drvrs    (4),
        .pckg_sz  (16),
        .broadcast(8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pndng (pndng),
        .push  (push),
        .pop   (pop),
        .D_pop (D_pop),
        .D_push(D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned src;
        logic [15:0] pkt;
        logic [3:0]  exp_push;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] onehot;
        checks = 0;
        passed = 0;
        reset  = 1'b0;
        pndng  = '0;
        D_pop  = '0;

        // Single-packet transactions: source, packet, expected push mask.
        vecs[0].src = 1; vecs[0].pkt = 16'h02AB; vecs[0].exp_push = 4'b0100;
        vecs[1].src = 3; vecs[1].pkt = 16'hFF5A;
`ifdef BCAST_LOOPBACK_EN
        vecs[1].exp_push = 4'b1111;
`else
        vecs[1].exp_push = 4'b0111;
`endif
        vecs[2].src = 0; vecs[2].pkt = 16'h07C3; vecs[2].exp_push = 4'b0000;
        vecs[3].src = 2; vecs[3].pkt = 16'h0211; vecs[3].exp_push = 4'b0100;
        vecs[4].src = 0; vecs[4].pkt = 16'h0355; vecs[4].exp_push = 4'b1000;
        vecs[5].src = 0; vecs[5].pkt = 16'hFF00;
`ifdef BCAST_LOOPBACK_EN
        vecs[5].exp_push = 4'b1111;
`else
        vecs[5].exp_push = 4'b1110;
`endif

        // Reset pulse.
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        check("reset_push", 64'(push), 64'h0);
        check("reset_pop", 64'(pop), 64'h0);
        check("reset_dpush", 64'(D_push), 64'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_push", 64'(push), 64'h0);
            check("idle_pop", 64'(pop), 64'h0);
        end

        // Table-driven transactions.
        for (int v = 0; v < 6; v++) begin
            onehot = 4'b0001 << vecs[v].src;
            pndng[0][vecs[v].src] = 1'b1;
            D_pop[0][vecs[v].src] = vecs[v].pkt;
            tick();
            check("vec_pop", 64'(pop), 64'(onehot));
            check("vec_pop_nopush", 64'(push), 64'h0);
            pndng = '0;
            tick();
            check("vec_pop_off", 64'(pop), 64'h0);
            check("vec_push", 64'(push), 64'(vecs[v].exp_push));
            check("vec_dpush", 64'(D_push), {4{vecs[v].pkt}});
            tick();
            check("vec_push_off", 64'(push), 64'h0);
            check("vec_dpush_hold", 64'(D_push), {4{vecs[v].pkt}});
        end

        // Round-robin fairness: pointer back to 0, all terminals pending.
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            D_pop[0][k] = {6'd0, 2'(k + 1), 4'(k), 4'h0};
        end
        pndng = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("rr_pop", 64'(pop), 64'(4'b0001 << (t % 4)));
            tick();
            check("rr_push", 64'(push), 64'(4'b0001 << ((t + 1) % 4)));
            check("rr_gap_pop", 64'(pop), 64'h0);
            tick();
            check("rr_idle_pop", 64'(pop), 64'h0);
        end
        pndng = '0;
        tick();
        tick();
        tick();

        // Reset asserted during the POP cycle of a transaction from terminal 2.
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        D_pop[0][2] = 16'h01AA;
        pndng[0][2] = 1'b1;
        tick();
        check("mid_pop", 64'(pop), 64'(4'b0100));
        #1 reset = 1'b1;
        #1;
        check("mid_pop_clr", 64'(pop), 64'h0);
        check("mid_push_clr", 64'(push), 64'h0);
        check("mid_dpush_clr", 64'(D_push), 64'h0);
        pndng = '0;
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_no_push", 64'(push), 64'h0);
            check("mid_no_pop", 64'(pop), 64'h0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
